// File: rtl/pwm_mon_pkg.sv
// Shared definitions for the PWM dead-time monitor: FSM state encoding and default sizing.
// Optional input synchronizers are enabled with the PWMMON_SYNC_EN macro.
package pwm_mon_pkg;

    localparam int CW_DEF     = 6;
    localparam int DT_MIN_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_DEAD1,
        ST_LOW,
        ST_DEAD2
    } state_t;

endpackage

// File: rtl/pwm_edge_det.sv
// Edge detector for one gate-drive input, with an optional 2-flop synchronizer (PWMMON_SYNC_EN).
// level is the (possibly synchronized) input; rise/fall compare it against its registered copy.
module pwm_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sig_d;

`ifdef PWMMON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], sig_in};
    end

    assign level = sync_q[1];
`else
    assign level = sig_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_d <= 1'b0;
        else     sig_d <= level;
    end

    assign rise = level & ~sig_d;
    assign fall = ~level & sig_d;

endmodule

// File: rtl/pwm_deadtime_monitor.sv
// Measures on-times, dead-times and period of a high/low gate-drive pair; flags overlap and short dead-time.
// Define PWMMON_SYNC_EN to synchronize hs_in/ls_in (adds 2 clk of latency).
module pwm_deadtime_monitor
    import pwm_mon_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int DT_MIN = DT_MIN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_in,
    input  logic        ls_in,
    input  logic        fault_clr,
    output logic [CW:0] duty_meas,
    output logic [CW:0] dt_rise,
    output logic [CW:0] low_meas,
    output logic [CW:0] dt_fall,
    output logic [CW:0] period_meas,
    output logic        meas_valid,
    output logic        dt_viol,
    output logic        fault_overlap,
    output logic        timeout
);

    localparam int          MW       = CW + 1;
    localparam logic [CW:0] CNT_MAX  = '1;
    localparam logic [CW:0] ONE      = MW'(1);
    localparam logic [CW:0] DT_MIN_V = MW'(DT_MIN);

    function automatic logic [CW:0] sat_inc(input logic [CW:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    logic hs_lvl, hs_rise, hs_fall;
    logic ls_lvl, ls_rise, ls_fall;

    pwm_edge_det u_hs_det (
        .clk   (clk),
        .rst   (rst),
        .sig_in(hs_in),
        .level (hs_lvl),
        .rise  (hs_rise),
        .fall  (hs_fall)
    );

    pwm_edge_det u_ls_det (
        .clk   (clk),
        .rst   (rst),
        .sig_in(ls_in),
        .level (ls_lvl),
        .rise  (ls_rise),
        .fall  (ls_fall)
    );

    state_t      state;
    logic [CW:0] duty_cnt, dtr_cnt, low_cnt, dtf_cnt, per_cnt;

    // Counters restart on every period start, so a DEAD1 or LOW publish already carries zero for the phases not reached.
    logic pub_now, start_now, tout_now;

    assign pub_now   = hs_rise && ((state == ST_DEAD1) || (state == ST_DEAD2) ||
                                   ((state == ST_LOW) && ls_fall));
    assign start_now = pub_now || (hs_rise && (state == ST_IDLE));
    assign tout_now  = (state != ST_IDLE) && !start_now && (sat_inc(per_cnt) == CNT_MAX);

    // NOTE: all sequential state below is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            duty_cnt      <= '0;
            dtr_cnt       <= '0;
            low_cnt       <= '0;
            dtf_cnt       <= '0;
            per_cnt       <= '0;
            duty_meas     <= '0;
            dt_rise       <= '0;
            low_meas      <= '0;
            dt_fall       <= '0;
            period_meas   <= '0;
            meas_valid    <= 1'b0;
            dt_viol       <= 1'b0;
            fault_overlap <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            dt_viol    <= 1'b0;
            timeout    <= 1'b0;

            if (hs_lvl && ls_lvl) fault_overlap <= 1'b1;
            else if (fault_clr)   fault_overlap <= 1'b0;

            if (tout_now) begin
                timeout  <= 1'b1;
                state    <= ST_IDLE;
                duty_cnt <= '0;
                dtr_cnt  <= '0;
                low_cnt  <= '0;
                dtf_cnt  <= '0;
                per_cnt  <= '0;
            end else if (start_now) begin
                if (pub_now) begin
                    duty_meas   <= duty_cnt;
                    dt_rise     <= dtr_cnt;
                    low_meas    <= low_cnt;
                    dt_fall     <= dtf_cnt;
                    period_meas <= per_cnt;
                    meas_valid  <= 1'b1;
                    dt_viol     <= (dtr_cnt < DT_MIN_V) || (dtf_cnt < DT_MIN_V);
                end
                state    <= ST_HIGH;
                duty_cnt <= ONE;
                per_cnt  <= ONE;
                dtr_cnt  <= '0;
                low_cnt  <= '0;
                dtf_cnt  <= '0;
            end else if (state != ST_IDLE) begin
                per_cnt <= sat_inc(per_cnt);
                case (state)
                    ST_HIGH: begin
                        if (hs_fall && ls_lvl) begin
                            state   <= ST_LOW;
                            low_cnt <= ONE;
                        end else if (hs_fall) begin
                            state   <= ST_DEAD1;
                            dtr_cnt <= ONE;
                        end else begin
                            duty_cnt <= sat_inc(duty_cnt);
                        end
                    end
                    ST_DEAD1: begin
                        if (ls_rise) begin
                            state   <= ST_LOW;
                            low_cnt <= ONE;
                        end else begin
                            dtr_cnt <= sat_inc(dtr_cnt);
                        end
                    end
                    ST_LOW: begin
                        if (ls_fall) begin
                            state   <= ST_DEAD2;
                            dtf_cnt <= ONE;
                        end else begin
                            low_cnt <= sat_inc(low_cnt);
                        end
                    end
                    ST_DEAD2: dtf_cnt <= sat_inc(dtf_cnt);
                    default:  state   <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_monitor.sv
// Self-checking bench for pwm_deadtime_monitor: waveform-segmentation model plus directed literal checks.
// Honors PWMMON_SYNC_EN by delaying the model's view of the gate inputs by 2 clk.
module tb_pwm_deadtime_monitor;

    localparam int MAXC   = 127;
    localparam int DT_MIN = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs_in, ls_in, fault_clr;
    logic [6:0] duty_meas, dt_rise, low_meas, dt_fall, period_meas;
    logic       meas_valid, dt_viol, fault_overlap, timeout;

    pwm_deadtime_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .hs_in        (hs_in),
        .ls_in        (ls_in),
        .fault_clr    (fault_clr),
        .duty_meas    (duty_meas),
        .dt_rise      (dt_rise),
        .low_meas     (low_meas),
        .dt_fall      (dt_fall),
        .period_meas  (period_meas),
        .meas_valid   (meas_valid),
        .dt_viol      (dt_viol),
        .fault_overlap(fault_overlap),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: keep every (hs,ls) sample since the last hs rise; at the next rise split the window into
    // hs-high run, ls-low run, ls-high run and remainder.
    logic [1:0] win[$];
    bit         m_active;
    logic       m_prev_hs;
    logic [1:0] m_pipe_hs, m_pipe_ls;
    int         e_duty, e_dtr, e_low, e_dtf, e_per;
    logic       e_valid, e_viol, e_fault, e_tout;

    task automatic model_reset();
        win.delete();
        m_active  = 1'b0;
        m_prev_hs = 1'b0;
        m_pipe_hs = '0;
        m_pipe_ls = '0;
        e_duty = 0; e_dtr = 0; e_low = 0; e_dtf = 0; e_per = 0;
        e_valid = 1'b0; e_viol = 1'b0; e_fault = 1'b0; e_tout = 1'b0;
    endtask

    task automatic model_step();
        logic s_hs, s_ls;
        int   i, d, dr, lo;
`ifdef PWMMON_SYNC_EN
        s_hs = m_pipe_hs[1];
        s_ls = m_pipe_ls[1];
        m_pipe_hs = {m_pipe_hs[0], hs_in};
        m_pipe_ls = {m_pipe_ls[0], ls_in};
`else
        s_hs = hs_in;
        s_ls = ls_in;
`endif
        e_valid = 1'b0;
        e_viol  = 1'b0;
        e_tout  = 1'b0;
        if (s_hs && s_ls) e_fault = 1'b1;
        else if (fault_clr) e_fault = 1'b0;
        if (s_hs && !m_prev_hs) begin
            if (m_active) begin
                i = 0;
                while (i < win.size() && win[i][1]) i++;
                d = i;
                while (i < win.size() && !win[i][0]) i++;
                dr = i - d;
                while (i < win.size() && win[i][0]) i++;
                lo = i - d - dr;
                e_duty = d; e_dtr = dr; e_low = lo;
                e_dtf  = win.size() - i;
                e_per  = win.size();
                e_valid = 1'b1;
                e_viol  = (e_dtr < DT_MIN) || (e_dtf < DT_MIN);
            end
            win.delete();
            win.push_back({s_hs, s_ls});
            m_active = 1'b1;
        end else if (m_active) begin
            win.push_back({s_hs, s_ls});
            if (win.size() == MAXC) begin
                e_tout   = 1'b1;
                m_active = 1'b0;
                win.delete();
            end
        end
        m_prev_hs = s_hs;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Compare process plus event bookkeeping for the directed checks.
    int   cyc = 0, n_valid = 0, n_tout = 0, valid_cyc = 0, tout_cyc = 0;
    logic last_viol = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("meas_valid", meas_valid, e_valid);
            check("dt_viol", dt_viol, e_viol);
            check("timeout", timeout, e_tout);
            check("fault_overlap", fault_overlap, e_fault);
            check("duty_meas", duty_meas, e_duty);
            check("dt_rise", dt_rise, e_dtr);
            check("low_meas", low_meas, e_low);
            check("dt_fall", dt_fall, e_dtf);
            check("period_meas", period_meas, e_per);
            if (meas_valid) begin
                n_valid++;
                valid_cyc = cyc;
                last_viol = dt_viol;
            end
            if (timeout) begin
                n_tout++;
                tout_cyc = cyc;
            end
        end
    end

    // Each call applies n samples; starts and ends on a falling clock edge.
    task automatic drive(input logic h, input logic l, input int n);
        for (int k = 0; k < n; k++) begin
            hs_in = h;
            ls_in = l;
            @(negedge clk);
        end
    endtask

    task automatic pwm_period(input int d, input int dr, input int lo, input int df);
        drive(1'b1, 1'b0, d);
        drive(1'b0, 1'b0, dr);
        drive(1'b0, 1'b1, lo);
        drive(1'b0, 1'b0, df);
    endtask

    task automatic expect_fields(input string tag, input int d, input int dr, input int lo,
                                 input int df, input int per);
        check({tag, "_duty"}, duty_meas, d);
        check({tag, "_dt_rise"}, dt_rise, dr);
        check({tag, "_low"}, low_meas, lo);
        check({tag, "_dt_fall"}, dt_fall, df);
        check({tag, "_period"}, period_meas, per);
    endtask

    int v0, nv, nt;

    initial begin
        hs_in = 1'b0; ls_in = 1'b0; fault_clr = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_duty", duty_meas, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_fault", fault_overlap, 0);
        rst = 1'b0;

        // Nominal generator: first period after reset is not published.
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 6);
        pwm_period(20, 6, 32, 6);
        check("first_unpublished", n_valid, 0);
        pwm_period(20, 6, 32, 6);
        check("nominal_count", n_valid, 1);
        expect_fields("nominal", 20, 6, 32, 6, 64);
        check("nominal_viol", last_viol, 0);
        v0 = valid_cyc;

        // Short rising dead-time.
        pwm_period(20, 4, 32, 6);
        check("valid_spacing", valid_cyc - v0, 64);
        pwm_period(20, 6, 32, 6);
        expect_fields("short_dt", 20, 4, 32, 6, 62);
        check("short_dt_viol", last_viol, 1);

        // Overlap while hs is high; FSM keeps measuring.
        drive(1'b1, 1'b0, 5);
        drive(1'b1, 1'b1, 3);
        drive(1'b1, 1'b0, 12);
        drive(1'b0, 1'b0, 6);
        drive(1'b0, 1'b1, 32);
        drive(1'b0, 1'b0, 6);
        check("overlap_set", fault_overlap, 1);
        fault_clr = 1'b1;
        drive(1'b1, 1'b0, 1);
        fault_clr = 1'b0;
        check("overlap_clr", fault_overlap, 0);
        drive(1'b1, 1'b0, 4);
        fault_clr = 1'b1;
        drive(1'b1, 1'b1, 1);
        fault_clr = 1'b0;
        check("overlap_set_wins", fault_overlap, 1);
        drive(1'b1, 1'b0, 14);
        drive(1'b0, 1'b0, 6);
        drive(1'b0, 1'b1, 32);
        drive(1'b0, 1'b0, 6);
        expect_fields("overlap_period", 20, 6, 32, 6, 64);

        // Asynchronous reset in the middle of a LOW phase.
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 6);
        drive(1'b0, 1'b1, 10);
        #3 rst = 1'b1;
        #1;
        check("midrst_fault", fault_overlap, 0);
        check("midrst_duty", duty_meas, 0);
        check("midrst_period", period_meas, 0);
        @(negedge clk);
        rst = 1'b0;
        nv = n_valid;
        drive(1'b0, 1'b1, 22);
        drive(1'b0, 1'b0, 6);
        pwm_period(20, 6, 32, 6);
        check("post_rst_unpublished", n_valid - nv, 0);
        pwm_period(20, 6, 32, 6);
        check("post_rst_count", n_valid - nv, 1);
        expect_fields("post_rst", 20, 6, 32, 6, 64);

        // hs stuck high: publishes the prior period, then one timeout 126 clk after that publish.
        nv = n_valid;
        nt = n_tout;
        drive(1'b1, 1'b0, 140);
        check("stuck_valid", n_valid - nv, 1);
        check("stuck_timeout", n_tout - nt, 1);
        check("stuck_timeout_pos", tout_cyc - valid_cyc, 126);

        // hs never high after one pulse following reset: timeout only, fields stay 0.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nv = n_valid;
        nt = n_tout;
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 200);
        check("dn0_valid", n_valid - nv, 0);
        check("dn0_timeout", n_tout - nt, 1);
        check("dn0_duty", duty_meas, 0);
        check("dn0_period", period_meas, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
